// File: rtl/program_loader_pkg.sv
// Shared types for the program loader: FSM state encoding and word geometry helpers.
package program_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int BYTE_W = 8;

  function automatic int bytes_per_word(input int width);
    return width / BYTE_W;
  endfunction

endpackage

// File: rtl/program_loader_word_packer.sv
// Little-endian byte packer: byte k of a word lands in bits [8k+7:8k].
// o_word already contains the byte being strobed so the caller can latch a complete word.
module word_packer
  import program_loader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_strobe,
  input  logic [7:0]       i_data,
  output logic [WIDTH-1:0] o_word,
  output logic             o_last
);

  localparam int BPW = bytes_per_word(WIDTH);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] w_word;

  always_comb begin
    w_word = r_word;
    if (i_strobe) w_word[int'(r_cnt)*BYTE_W +: BYTE_W] = i_data;
  end

  assign o_word = w_word;
  assign o_last = (r_cnt == CW'(BPW - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_strobe) begin
      r_word <= w_word;
      r_cnt  <= o_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a byte-streamed program into instruction memory, verifies an XOR checksum
// byte, and holds the CPU in reset until the load completes.
//
// state   | meaning
// IDLE    | waiting for first start
// RECV    | accepting program bytes into the packer
// WRITE   | one-cycle memory write of the packed word
// CHECK   | accepting the trailing checksum byte
// DONE    | load finished, CPU released
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 mem_wen,
  output logic [ADD_WIDTH-1:0] mem_add,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 chk_err
);

  localparam logic [ADD_WIDTH-1:0] ADD_LAST = ADD_WIDTH'(DEPTH - 1);

  state_t               r_state;
  logic                 r_rx_ready;
  logic                 r_mem_wen;
  logic [ADD_WIDTH-1:0] r_mem_add;
  logic [WIDTH-1:0]     r_mem_wdata;
  logic                 r_cpu_hold;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_chk_err;
  logic [7:0]           r_csum;

  logic             w_xfer;
  logic             w_start_ok;
  logic             w_strobe;
  logic [WIDTH-1:0] w_word;
  logic             w_last;

  // rx_ready is registered, so a transfer is only possible in states that raised it
  assign w_xfer     = rx_valid & r_rx_ready;
  assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_strobe   = w_xfer & (r_state == S_RECV);

  word_packer #(.WIDTH(WIDTH)) u_packer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_start_ok),
    .i_strobe (w_strobe),
    .i_data   (rx_data),
    .o_word   (w_word),
    .o_last   (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_rx_ready  <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_add   <= '0;
      r_mem_wdata <= '0;
      r_cpu_hold  <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_chk_err   <= 1'b0;
      r_csum      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_RECV;
            r_rx_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_chk_err  <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_mem_add  <= '0;
            r_csum     <= '0;
          end
        end
        S_RECV: begin
          if (w_xfer) begin
            r_csum <= r_csum ^ rx_data;
            if (w_last) begin
              r_state     <= S_WRITE;
              r_rx_ready  <= 1'b0;
              r_mem_wen   <= 1'b1;
              r_mem_wdata <= w_word;
            end
          end
        end
        S_WRITE: begin
          r_mem_wen  <= 1'b0;
          r_rx_ready <= 1'b1;
          if (r_mem_add == ADD_LAST) begin
            r_state <= S_CHECK;
          end else begin
            r_mem_add <= r_mem_add + ADD_WIDTH'(1);
            r_state   <= S_RECV;
          end
        end
        S_CHECK: begin
          if (w_xfer) begin
            r_chk_err  <= (rx_data != r_csum);
            r_state    <= S_DONE;
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_ready  = r_rx_ready;
  assign mem_wen   = r_mem_wen;
  assign mem_add   = r_mem_add;
  assign mem_wdata = r_mem_wdata;
  assign cpu_hold  = r_cpu_hold;
  assign busy      = r_busy;
  assign done      = r_done;
  assign chk_err   = r_chk_err;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: reset, packing, full loads, checksum, stalls, restart.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_wen;
  logic [3:0]  mem_add;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        chk_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [3:0]  wr_add_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] model_mem[16];

  program_loader #(.DEPTH(16), .WIDTH(32), .ADD_WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_wen   (mem_wen),
    .mem_add   (mem_add),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .chk_err   (chk_err)
  );

  always #5 clk = ~clk;

  // program memory model: captures writes the CPU will later fetch
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wen === 1'b1) begin
      wr_add_q.push_back(mem_add);
      wr_data_q.push_back(mem_wdata);
      model_mem[mem_add] <= mem_wdata;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  n;
    logic acc;
    n = 0;
    acc = 1'b0;
    rx_data = b;
    rx_valid = 1'b1;
    while (!acc && n < 100) begin
      acc = rx_ready;
      tick();
      n++;
    end
    rx_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_byte: byte %02h not accepted within 100 cycles", b);
    end
  endtask

  function automatic logic [31:0] exp_word(input int i);
    return 32'h0000_0093 + (32'(i) << 20);
  endfunction

  task automatic begin_load(output int t0);
    wr_add_q.delete();
    wr_data_q.delete();
    pulse_start();
    t0 = cyc;
  endtask

  task automatic stream_load(input bit bad, input int max_gap, input int inject_at);
    logic [31:0] w;
    logic [7:0]  b;
    logic [7:0]  csum;
    csum = 8'h00;
    for (int i = 0; i < 16; i++) begin
      w = exp_word(i);
      for (int k = 0; k < 4; k++) begin
        if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
        if (inject_at == i * 4 + k) begin
          pulse_start();
          checks++;
          if (busy !== 1'b1 || mem_add !== 4'(i)) begin
            failures++;
            $display("FAIL start_while_busy: busy=%b mem_add=%0d, want busy=1 mem_add=%0d", busy, mem_add, i);
          end
        end
        b = w[k*8 +: 8];
        csum = csum ^ b;
        send_byte(b);
      end
    end
    if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
    send_byte(bad ? (csum ^ 8'h01) : csum);
  endtask

  task automatic check_load(input string name, input logic exp_err);
    logic [31:0] fetched;
    checks++;
    if (wr_add_q.size() != 16) begin
      failures++;
      $display("FAIL %s write_count: got %0d want 16", name, wr_add_q.size());
    end
    for (int i = 0; i < 16 && i < wr_add_q.size(); i++) begin
      checks++;
      if (wr_add_q[i] !== 4'(i) || wr_data_q[i] !== exp_word(i)) begin
        failures++;
        $display("FAIL %s write[%0d]: got add=%0d data=%08h want add=%0d data=%08h",
                 name, i, wr_add_q[i], wr_data_q[i], i, exp_word(i));
      end
    end
    for (int i = 0; i < 16; i++) begin
      fetched = model_mem[i];
      checks++;
      if (fetched !== exp_word(i)) begin
        failures++;
        $display("FAIL %s fetch[%0d]: got %08h want %08h", name, i, fetched, exp_word(i));
      end
    end
    checks++;
    if ({done, chk_err, cpu_hold, busy, rx_ready} !== {1'b1, exp_err, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL %s status: got done=%b chk_err=%b cpu_hold=%b busy=%b rx_ready=%b want 1 %b 0 0 0",
               name, done, chk_err, cpu_hold, busy, rx_ready, exp_err);
    end
    checks++;
    if (mem_add !== 4'd15) begin
      failures++;
      $display("FAIL %s final_add: got %0d want 15", name, mem_add);
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({rx_ready, mem_wen, cpu_hold, busy, done, chk_err} !== 6'b001000 ||
        mem_add !== 4'd0 || mem_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_initial: got rdy=%b wen=%b hold=%b busy=%b done=%b err=%b add=%0d wdata=%08h",
               rx_ready, mem_wen, cpu_hold, busy, done, chk_err, mem_add, mem_wdata);
    end
    rst = 1'b1;
    tick();
    pulse_start();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55);
    checks++;
    if (busy !== 1'b1 || rx_ready !== 1'b1 || mem_add !== 4'd1 || mem_wdata !== 32'h44332211) begin
      failures++;
      $display("FAIL reset_preload: got busy=%b rdy=%b add=%0d wdata=%08h want 1 1 1 44332211",
               busy, rx_ready, mem_add, mem_wdata);
    end
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({rx_ready, mem_wen, cpu_hold, busy, done, chk_err} !== 6'b001000 ||
        mem_add !== 4'd0 || mem_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_midload: got rdy=%b wen=%b hold=%b busy=%b done=%b err=%b add=%0d wdata=%08h",
               rx_ready, mem_wen, cpu_hold, busy, done, chk_err, mem_add, mem_wdata);
    end
    rst = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h77;
    repeat (2) tick();
    rx_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || rx_ready !== 1'b0 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle_after: got busy=%b rdy=%b hold=%b want 0 0 1", busy, rx_ready, cpu_hold);
    end
  endtask

  task automatic test_pack_order();
    int t0;
    begin_load(t0);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h50); send_byte(8'h00);
    checks++;
    if (mem_wen !== 1'b1 || mem_add !== 4'd0 || mem_wdata !== 32'h00500513 || rx_ready !== 1'b0) begin
      failures++;
      $display("FAIL pack_write: got wen=%b add=%0d wdata=%08h rdy=%b want 1 0 00500513 0",
               mem_wen, mem_add, mem_wdata, rx_ready);
    end
    rx_data = 8'hAA;
    rx_valid = 1'b1;
    tick();
    checks++;
    if (mem_wen !== 1'b0 || rx_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL write_backpressure: got wen=%b rdy=%b busy=%b want 0 1 1", mem_wen, rx_ready, busy);
    end
    tick();
    rx_valid = 1'b0;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    repeat (3) tick();
    checks++;
    if (wr_add_q.size() != 2) begin
      failures++;
      $display("FAIL pack_count: got %0d writes want 2", wr_add_q.size());
    end else begin
      checks++;
      if (wr_add_q[0] !== 4'd0 || wr_data_q[0] !== 32'h00500513) begin
        failures++;
        $display("FAIL pack_word0: got add=%0d data=%08h want 0 00500513", wr_add_q[0], wr_data_q[0]);
      end
      checks++;
      if (wr_add_q[1] !== 4'd1 || wr_data_q[1] !== 32'h332211AA) begin
        failures++;
        $display("FAIL pack_word1: got add=%0d data=%08h want 1 332211aa", wr_add_q[1], wr_data_q[1]);
      end
    end
    checks++;
    if (mem_wdata !== 32'h332211AA || mem_wen !== 1'b0) begin
      failures++;
      $display("FAIL wdata_hold: got wdata=%08h wen=%b want 332211aa 0", mem_wdata, mem_wen);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_full_load();
    int t0;
    begin_load(t0);
    stream_load(1'b0, 0, -1);
    check_load("full_load", 1'b0);
    checks++;
    if (cyc - t0 != 81) begin
      failures++;
      $display("FAIL load_time: got %0d cycles want 81", cyc - t0);
    end
  endtask

  task automatic test_backpressure();
    int t0;
    begin_load(t0);
    stream_load(1'b0, 3, -1);
    check_load("backpressure", 1'b0);
  endtask

  task automatic test_bad_checksum();
    int t0;
    begin_load(t0);
    stream_load(1'b1, 0, -1);
    check_load("bad_checksum", 1'b1);
  endtask

  task automatic test_restart();
    int t0;
    begin_load(t0);
    checks++;
    if ({done, chk_err, cpu_hold, busy, rx_ready} !== 5'b00111 || mem_add !== 4'd0) begin
      failures++;
      $display("FAIL restart_from_done: got done=%b err=%b hold=%b busy=%b rdy=%b add=%0d want 0 0 1 1 1 0",
               done, chk_err, cpu_hold, busy, rx_ready, mem_add);
    end
    stream_load(1'b0, 0, 5);
    check_load("restart", 1'b0);
  endtask

  initial begin
    test_reset();
    test_pack_order();
    test_full_load();
    test_backpressure();
    test_bad_checksum();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
